// File: rtl/windowed_rf_pkg.sv
// Shared types and constants for the windowed register file: window-op
// encoding, transfer FSM states and register-segment numbering.
package windowed_rf_pkg;

  typedef enum logic [1:0] {
    OP_NONE    = 2'b00,
    OP_SAVE    = 2'b01,
    OP_RESTORE = 2'b10,
    OP_RSVD    = 2'b11
  } win_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SPILL,
    ST_FILL
  } rf_state_e;

  localparam int SEG_IN    = 0;
  localparam int SEG_LOCAL = 1;
  localparam int SEG_OUT   = 2;

endpackage

// File: rtl/rf_window_map.sv
// Combinational translation of (architectural index, window) to a physical
// register index. Globals occupy the bottom NGLOB entries, window blocks follow.
module rf_window_map
  import windowed_rf_pkg::*;
#(
  parameter int NGLOB = 2,
  parameter int NSEG  = 2,
  parameter int NWIN  = 4,
  parameter int AW    = 3,
  parameter int WW    = 2,
  parameter int PW    = 5
) (
  input  logic [AW-1:0] arch_idx,
  input  logic [WW-1:0] win,
  output logic [PW-1:0] phys_idx
);

  int rel;
  int seg;
  int off;
  int blk;

  // NOTE: every variable gets a value on every path through always_comb,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    rel = int'(arch_idx) - NGLOB;
    seg = rel / NSEG;
    off = rel % NSEG;
    blk = 2 * int'(win);
    case (seg)
      SEG_IN:    blk = 2 * int'(win);
      SEG_LOCAL: blk = 2 * int'(win) + 1;
      SEG_OUT:   blk = (2 * int'(win) + 2) % (2 * NWIN);
      default:   blk = 2 * int'(win);
    endcase
    if (int'(arch_idx) < NGLOB) phys_idx = PW'(arch_idx);
    else                        phys_idx = PW'(NGLOB + blk * NSEG + off);
  end

endmodule

// File: rtl/windowed_regfile.sv
// Register file with overlapping windows, globals and a CWP; window overflow
// and underflow spill to / fill from a backing memory while busy stalls decode.
module windowed_regfile
  import windowed_rf_pkg::*;
#(
  parameter  int DATA_W      = 16,
  parameter  int NGLOB       = 2,
  parameter  int NSEG        = 2,
  parameter  int NWIN        = 4,
  parameter  int SPILL_DEPTH = 16,
  parameter  int MEM_AW      = 8,
  localparam int AW          = $clog2(NGLOB + 3 * NSEG),
  localparam int CWP_W       = $clog2(NWIN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     readReg1,
  input  logic [AW-1:0]     readReg2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  input  logic              regWrite,
  input  logic [AW-1:0]     writeReg,
  input  logic [DATA_W-1:0] writeData,
  input  logic              win_valid,
  input  logic [1:0]        win_op,
  output logic              busy,
  output logic [CWP_W-1:0]  cwp,
  output logic              win_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int NPHYS = NGLOB + 2 * NWIN * NSEG;
  localparam int PW    = $clog2(NPHYS);
  localparam int XFERS = 2 * NSEG;
  localparam int IDX_W = $clog2(XFERS);
  localparam int SP_W  = $clog2(SPILL_DEPTH + 1);

  function automatic logic [CWP_W-1:0] win_add(input int w, input int d);
    return CWP_W'(((w + d) % NWIN + NWIN) % NWIN);
  endfunction

  logic [DATA_W-1:0] rf [NPHYS];
  rf_state_e         state;
  logic [CWP_W-1:0]  depth;
  logic [CWP_W-1:0]  xfer_win;
  logic [SP_W-1:0]   sp;
  logic [IDX_W-1:0]  idx;
  logic [PW-1:0]     rd1_phys, rd2_phys, wr_phys, xfer_phys;
  logic [AW-1:0]     xfer_arch;
  win_op_e           op;
  logic              accept;
  logic              last_ack;

  assign op        = win_op_e'(win_op);
  assign accept    = win_valid && (state == ST_IDLE);
  // In and local segments are contiguous right after the globals.
  assign xfer_arch = AW'(NGLOB + int'(idx));
  assign last_ack  = mem_ack && (int'(idx) == XFERS - 1);

  rf_window_map #(.NGLOB(NGLOB), .NSEG(NSEG), .NWIN(NWIN), .AW(AW), .WW(CWP_W), .PW(PW))
    u_map_rd1 (.arch_idx(readReg1), .win(cwp), .phys_idx(rd1_phys));
  rf_window_map #(.NGLOB(NGLOB), .NSEG(NSEG), .NWIN(NWIN), .AW(AW), .WW(CWP_W), .PW(PW))
    u_map_rd2 (.arch_idx(readReg2), .win(cwp), .phys_idx(rd2_phys));
  rf_window_map #(.NGLOB(NGLOB), .NSEG(NSEG), .NWIN(NWIN), .AW(AW), .WW(CWP_W), .PW(PW))
    u_map_wr (.arch_idx(writeReg), .win(cwp), .phys_idx(wr_phys));
  rf_window_map #(.NGLOB(NGLOB), .NSEG(NSEG), .NWIN(NWIN), .AW(AW), .WW(CWP_W), .PW(PW))
    u_map_xfer (.arch_idx(xfer_arch), .win(xfer_win), .phys_idx(xfer_phys));

  assign readData1 = rf[rd1_phys];
  assign readData2 = rf[rd2_phys];
  // Register contents are frozen during a spill, so the selected word is stable until ack.
  assign mem_wdata = mem_we ? rf[xfer_phys] : '0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cwp      <= '0;
      depth    <= CWP_W'(1);
      sp       <= '0;
      idx      <= '0;
      xfer_win <= '0;
      busy     <= 1'b0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      win_err  <= 1'b0;
      // NOTE: the array is reset explicitly because software relies on
      // architectural registers reading zero after reset.
      for (int i = 0; i < NPHYS; i++) rf[i] <= '0;
    end else begin
      win_err <= 1'b0;
      if (regWrite && !busy) rf[wr_phys] <= writeData;

      case (state)
        ST_IDLE: begin
          if (accept && op == OP_SAVE) begin
            if (int'(depth) < NWIN - 1) begin
              cwp   <= win_add(int'(cwp), 1);
              depth <= depth + CWP_W'(1);
            end else if (int'(sp) == SPILL_DEPTH) begin
              win_err <= 1'b1;
            end else begin
              state    <= ST_SPILL;
              xfer_win <= win_add(int'(cwp), 1 - int'(depth));
              busy     <= 1'b1;
              mem_req  <= 1'b1;
              mem_we   <= 1'b1;
              mem_addr <= MEM_AW'(int'(sp) * XFERS);
            end
          end else if (accept && op == OP_RESTORE) begin
            if (int'(depth) > 1) begin
              cwp   <= win_add(int'(cwp), -1);
              depth <= depth - CWP_W'(1);
            end else if (sp == '0) begin
              win_err <= 1'b1;
            end else begin
              state    <= ST_FILL;
              xfer_win <= win_add(int'(cwp), -1);
              busy     <= 1'b1;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= MEM_AW'((int'(sp) - 1) * XFERS);
            end
          end
        end

        ST_SPILL, ST_FILL: begin
          if (mem_ack) begin
            if (state == ST_FILL) rf[xfer_phys] <= mem_rdata;
            if (last_ack) begin
              state    <= ST_IDLE;
              idx      <= '0;
              busy     <= 1'b0;
              mem_req  <= 1'b0;
              mem_we   <= 1'b0;
              mem_addr <= '0;
              if (state == ST_SPILL) begin
                cwp <= win_add(int'(cwp), 1);
                sp  <= sp + SP_W'(1);
              end else begin
                cwp <= win_add(int'(cwp), -1);
                sp  <= sp - SP_W'(1);
              end
            end else begin
              idx      <= idx + IDX_W'(1);
              mem_addr <= mem_addr + MEM_AW'(1);
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/windowed_regfile.md
# windowed_regfile

Parametrised register file with overlapping register windows for the pipeline processor. It extends the 8×16 bank with an arbitrary number of windows, global registers and a current-window pointer (CWP) driven by save/restore operations. Window overflow and underflow are handled in hardware by spilling to, and filling from, a backing memory through a req/ack port. It sits in the decode stage and stalls the pipeline via `busy` while a spill or fill runs.

## Interface
- `DATA_W`, 16, register width
- `NGLOB`, 2, global registers shared by all windows
- `NSEG`, 2, registers per in/local/out segment
- `NWIN`, 4, physical windows (≥2)
- `SPILL_DEPTH`, 16, maximum spilled windows in backing memory
- `MEM_AW`, 8, backing-memory address width (≥ clog2(SPILL_DEPTH·2·NSEG))
- Derived: `AW` = clog2(NGLOB+3·NSEG), the architectural index width (3 with defaults)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `readReg1`, `readReg2`  in  AW  architectural read indices
- `readData1`, `readData2`  out  DATA_W  combinational read data
- `regWrite`  in  1  write enable
- `writeReg`  in  AW  write index
- `writeData`  in  DATA_W  write data
- `win_valid`  in  1  window op request
- `win_op`  in  2  00 none, 01 save, 10 restore, 11 reserved (ignored)
- `busy`  out  1  spill/fill in progress; ops and writes ignored
- `cwp`  out  clog2(NWIN)  current window pointer
- `win_err`  out  1  one-cycle pulse: underflow, or spill stack full
- `mem_req`, `mem_we`  out  1  backing-memory request / write
- `mem_addr`  out  MEM_AW  backing-memory word address
- `mem_wdata`  out  DATA_W
- `mem_rdata`  in  DATA_W
- `mem_ack`  in  1  transfer complete, sampled on rising edge

## Operation
- Arch index a < NGLOB → global a. Remaining indices in order: in segment, then local, then out (defaults: r0–r1 global, r2–r3 in, r4–r5 local, r6–r7 out).
- Physical window blocks are numbered 0..2·NWIN−1, each NSEG regs. Window w maps in → block 2w, local → 2w+1, out → (2w+2) mod 2·NWIN. After a save, the new window's ins alias the old window's outs.
- State: `cwp`, `depth` (resident windows, 1..NWIN−1), `sp` (spilled windows, 0..SPILL_DEPTH), FSM {IDLE, SPILL, FILL}, transfer index `idx` (0..2·NSEG−1).
- Save in IDLE:
  - if depth<NWIN−1: cwp+1 mod NWIN, depth+1.
  - else if sp==SPILL_DEPTH: win_err, no change.
  - else → SPILL of oldest window (cwp−depth+1): its in then local registers, idx 0..2·NSEG−1.
- Restore in IDLE:
  - if depth>1: cwp−1, depth−1.
  - else if sp==0: win_err, no change.
  - else → FILL of window cwp−1, in then local, from mem_addr (sp−1)·2·NSEG+idx.
- SPILL: mem_we=1, mem_addr=sp·2·NSEG+idx, mem_wdata=register[idx].
- FILL: mem_we=0; on ack, mem_rdata is written to the target register.
- After the last ack:
  - SPILL → cwp+1, sp+1, depth unchanged.
  - FILL → cwp−1, sp−1, depth unchanged.
  - Either way → IDLE.
- Write in the same cycle as an accepted op uses the pre-op cwp. `regWrite` is ignored while busy.

## Timing
- Reset: all registers 0, cwp=0, depth=1, sp=0, IDLE, busy=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, win_err=0.
- Reads combinational; no write bypass. A value written on edge N is visible after edge N.
- Non-spilling save/restore: cwp updates on the accepting edge; busy stays 0.
- Spill/fill: busy and mem_req rise on the accepting edge. Address and data are held until mem_ack; idx advances per ack. busy and mem_req drop on the last-ack edge, together with the cwp update.
- A 2·NSEG-transfer op with zero-wait ack takes 2·NSEG cycles of busy.
- win_err pulses on the edge after the rejected request.
- win_valid while busy is ignored, not queued.
- rst mid-spill/fill aborts immediately. mem_req drops asynchronously; partial memory contents are don't-care.

## Structure
- Package `windowed_rf_pkg`: win_op encoding, FSM state enum, segment constants (SEG_IN=0, SEG_LOCAL=1, SEG_OUT=2).
- Sub-module `rf_window_map`: (arch index, window) → physical index. It is combinational and instantiated for both read ports, the write port and the transfer path.

## Test plan
- Globals: write r0=0x1234, save, read r0 → 0x1234; cwp=1; busy never asserted.
- Overlap: in window 0 write r6=0xBEEF, save, read r2 → 0xBEEF; r4 reads 0.
- Spill: write window-0 r2..r5=0xA0..0xA3, then save ×3 with zero-wait ack.
  - Third save: busy 4 cycles, writes addr 0..3 = 0xA0..0xA3.
  - Afterwards cwp=3, sp=1.
- Fill: continuing, restore ×3.
  - Third restore: reads addr 0..3, busy 4 cycles.
  - Afterwards cwp=0, sp=0, r2..r5 = 0xA0..0xA3.
- Underflow: restore right after reset → win_err one cycle, cwp=0, no mem_req.
- Reset mid-spill: hold mem_ack=0 during a spill, assert rst → mem_req/busy 0 immediately, cwp=0, all reads 0.
